spram32_arb: RTL and testbench

SPRAM32_ARB -- requirements
Module: spram32_arb

---
 rtl/spram32_arb_if.sv | 58 +++++
 rtl/spram32_arb.sv | 149 ++++++++++++++
 tb/tb_spram32_arb.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spram32_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : spram32_arb_if
// Purpose  : Requester-side bundle for the two-port single-port-RAM arbiter.
//            Carries the request, write/read qualifier, address, byte mask
//            and write data of both requesters, plus the grant, read-valid
//            and read-data returned to each of them.
// Ports    : req0/req1    access request, held until granted
//            we0/we1      1 = write, 0 = read
//            a0/a1        word address (AW bits)
//            bmsk0/bmsk1  byte write mask (DW/8 bits)
//            vi0/vi1      write data (DW bits)
//            gnt0/gnt1    request accepted this cycle
//            rvld0/rvld1  read data valid
//            vo0/vo1      read data (zero when not valid)
// Revision : 1.0 - initial release
// ============================================================================
interface spram32_arb_if #(
  parameter int AW = 15,
  parameter int DW = 32
);

  logic            req0;
  logic            we0;
  logic [AW-1:0]   a0;
  logic [DW/8-1:0] bmsk0;
  logic [DW-1:0]   vi0;
  logic            gnt0;
  logic            rvld0;
  logic [DW-1:0]   vo0;

  logic            req1;
  logic            we1;
  logic [AW-1:0]   a1;
  logic [DW/8-1:0] bmsk1;
  logic [DW-1:0]   vi1;
  logic            gnt1;
  logic            rvld1;
  logic [DW-1:0]   vo1;

  // Requester side drives the request fields and observes the responses.
  modport master (
    output req0, we0, a0, bmsk0, vi0,
    output req1, we1, a1, bmsk1, vi1,
    input  gnt0, rvld0, vo0,
    input  gnt1, rvld1, vo1
  );

  // Arbiter side.
  modport slave (
    input  req0, we0, a0, bmsk0, vi0,
    input  req1, we1, a1, bmsk1, vi1,
    output gnt0, rvld0, vo0,
    output gnt1, rvld1, vo1
  );

endinterface : spram32_arb_if
`default_nettype wire

// File: rtl/spram32_arb.sv
`default_nettype none
// ============================================================================
// Module   : spram32_arb
// Purpose  : Round-robin arbiter sharing one synchronous single-port RAM
//            between two requesters. Writes complete in the grant cycle
//            (one per clock); reads take a grant cycle followed by a data
//            cycle in which the RAM address is held so the bank-select mux
//            on mem_vo stays on the bank that was read.
// Ports    : clk        single clock, rising edge
//            rst_n      asynchronous active-low reset
//            req_if     requester bundle (slave modport)
//            mem_ai     RAM word address
//            mem_vi     RAM write data
//            mem_bmsk   RAM byte write mask
//            mem_we     RAM write enable
//            mem_vo     RAM read data (valid one cycle after the address)
// Revision : 1.0 - initial release
// ============================================================================
module spram32_arb #(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  spram32_arb_if.slave         req_if,
  output logic [AW-1:0]        mem_ai,
  output logic [DW-1:0]        mem_vi,
  output logic [DW/8-1:0]      mem_bmsk,
  output logic                 mem_we,
  input  wire logic [DW-1:0]   mem_vo
);

  localparam int BW = DW / 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RDAT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t        state_q;
  logic          prio_q;    // 0: requester 0 preferred, 1: requester 1 preferred
  logic          owner_q;   // requester whose read is in flight
  logic [AW-1:0] addr_q;    // last address presented to the RAM

  // --------------------------------------------------------------------------
  // Arbitration and RAM-side next values
  // --------------------------------------------------------------------------
  logic          req0_v;
  logic          req1_v;
  logic          gnt0_d;
  logic          gnt1_d;
  logic          gnt_any_d;
  logic          win_d;      // 1 when requester 1 wins
  logic [AW-1:0] addr_d;
  logic          we_d;
  logic [BW-1:0] bmsk_d;
  logic [DW-1:0] vi_d;

  always_comb begin
    req0_v    = req_if.req0 && (state_q == ST_IDLE);
    req1_v    = req_if.req1 && (state_q == ST_IDLE);

    // A lone requester wins outright; the pointer only breaks ties.
    gnt0_d    = req0_v && (!req1_v || !prio_q);
    gnt1_d    = req1_v && (!req0_v ||  prio_q);
    gnt_any_d = gnt0_d || gnt1_d;
    win_d     = gnt1_d;

    // With no grant the address stays where it was: during RDAT this is the
    // latched read address, which keeps the bank mux on mem_vo stable.
    addr_d    = addr_q;
    we_d      = 1'b0;
    bmsk_d    = '0;
    vi_d      = '0;
    if (gnt_any_d) begin
      addr_d = win_d ? req_if.a1    : req_if.a0;
      we_d   = win_d ? req_if.we1   : req_if.we0;
      bmsk_d = win_d ? req_if.bmsk1 : req_if.bmsk0;
      vi_d   = win_d ? req_if.vi1   : req_if.vi0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The request path is combinational, so while rst_n is low every
  // request-derived output is forced quiet here rather than in the flops.
  assign req_if.gnt0 = rst_n && gnt0_d;
  assign req_if.gnt1 = rst_n && gnt1_d;

  assign mem_ai   = rst_n ? addr_d : '0;
  assign mem_we   = rst_n && we_d;
  assign mem_bmsk = rst_n ? bmsk_d : '0;
  assign mem_vi   = rst_n ? vi_d   : '0;

  // Read valid is decoded from registered state only; reset forces IDLE.
  assign req_if.rvld0 = (state_q == ST_RDAT) && !owner_q;
  assign req_if.rvld1 = (state_q == ST_RDAT) &&  owner_q;
  assign req_if.vo0   = req_if.rvld0 ? mem_vo : '0;
  assign req_if.vo1   = req_if.rvld1 ? mem_vo : '0;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_any_d) begin
            addr_q <= addr_d;
            prio_q <= !win_d;          // next tie goes to the other requester
            if (!we_d) begin
              state_q <= ST_RDAT;
              owner_q <= win_d;
            end
          end
        end
        ST_RDAT: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Protocol properties
  // --------------------------------------------------------------------------
  a_gnt_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(req_if.gnt0 && req_if.gnt1));

  a_no_write_in_rdat : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_RDAT) |-> !mem_we);

  a_no_write_without_gnt : assert property (@(posedge clk) disable iff (!rst_n)
    !(req_if.gnt0 || req_if.gnt1) |-> !mem_we);

endmodule : spram32_arb
`default_nettype wire

// File: tb/tb_spram32_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_spram32_arb
// Purpose  : Directed self-checking bench for spram32_arb with a two-bank
//            synchronous RAM model (bank chosen by the address MSB).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spram32_arb;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int BANK_WORDS = 2 ** (AW - 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spram32_arb_if #(.AW(AW), .DW(DW)) bus ();

  logic [AW-1:0] mem_ai;
  logic [DW-1:0] mem_vi;
  logic [BW-1:0] mem_bmsk;
  logic          mem_we;
  logic [DW-1:0] mem_vo;

  spram32_arb #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_if   (bus),
    .mem_ai   (mem_ai),
    .mem_vi   (mem_vi),
    .mem_bmsk (mem_bmsk),
    .mem_we   (mem_we),
    .mem_vo   (mem_vo)
  );

  // --------------------------------------------------------------------------
  // RAM model: two banks, registered read, output bank mux on current address
  // --------------------------------------------------------------------------
  logic [DW-1:0] bank0 [0:BANK_WORDS-1];
  logic [DW-1:0] bank1 [0:BANK_WORDS-1];
  logic [DW-1:0] rd0;
  logic [DW-1:0] rd1;

  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BW; b++) begin
        if (mem_bmsk[b]) begin
          if (mem_ai[AW-1]) bank1[mem_ai[AW-2:0]][8*b +: 8] <= mem_vi[8*b +: 8];
          else              bank0[mem_ai[AW-2:0]][8*b +: 8] <= mem_vi[8*b +: 8];
        end
      end
    end
    rd0 <= bank0[mem_ai[AW-2:0]];
    rd1 <= bank1[mem_ai[AW-2:0]];
  end

  assign mem_vo = mem_ai[AW-1] ? rd1 : rd0;

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic drive(input int n, input logic req, input logic we,
                       input logic [AW-1:0] a, input logic [BW-1:0] m,
                       input logic [DW-1:0] v);
    if (n == 0) begin
      bus.req0 = req; bus.we0 = we; bus.a0 = a; bus.bmsk0 = m; bus.vi0 = v;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.a1 = a; bus.bmsk1 = m; bus.vi1 = v;
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 1'b1, 1'b1, 15'h0010, 4'hF, 32'h5555_5555);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b0;

    // Reset: everything quiet even with a request pending.
    repeat (2) @(posedge clk);
    mid;
    check("rst_gnt0",  bus.gnt0,  0);
    check("rst_gnt1",  bus.gnt1,  0);
    check("rst_rvld0", bus.rvld0, 0);
    check("rst_rvld1", bus.rvld1, 0);
    check("rst_vo0",   bus.vo0,   0);
    check("rst_vo1",   bus.vo1,   0);
    check("rst_we",    mem_we,    0);
    check("rst_bmsk",  mem_bmsk,  0);
    check("rst_ai",    mem_ai,    0);
    check("rst_vi",    mem_vi,    0);

    // Single write, granted in the first cycle after release.
    next_cycle;
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b1, 15'h0010, 4'hF, 32'hDEAD_BEEF);
    mid;
    check("wr_gnt0", bus.gnt0, 1);
    check("wr_gnt1", bus.gnt1, 0);
    check("wr_we",   mem_we,   1);
    check("wr_ai",   mem_ai,   15'h0010);
    check("wr_vi",   mem_vi,   32'hDEAD_BEEF);
    check("wr_bmsk", mem_bmsk, 4'hF);

    // Back-to-back writes, one per cycle.
    next_cycle;
    drive(0, 1'b1, 1'b1, 15'h3FFF, 4'hF, 32'h1111_1111);
    mid;
    check("b2b_gnt0_a", bus.gnt0, 1);
    check("b2b_ai_a",   mem_ai,   15'h3FFF);
    next_cycle;
    drive(0, 1'b1, 1'b1, 15'h4000, 4'hF, 32'h2222_2222);
    mid;
    check("b2b_gnt0_b", bus.gnt0, 1);
    check("b2b_ai_b",   mem_ai,   15'h4000);
    next_cycle;
    drive(0, 1'b1, 1'b1, 15'h0020, 4'hF, 32'h1234_5678);
    mid;
    check("b2b_gnt0_c", bus.gnt0, 1);
    next_cycle;
    drive(0, 1'b1, 1'b1, 15'h0020, 4'h3, 32'hAAAA_BBBB);
    mid;
    check("pw_gnt0", bus.gnt0, 1);
    check("pw_bmsk", mem_bmsk, 4'h3);

    // Idle: no write, address parked at last driven value.
    next_cycle;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    mid;
    check("idle_gnt0", bus.gnt0, 0);
    check("idle_we",   mem_we,   0);
    check("idle_bmsk", mem_bmsk, 0);
    check("idle_ai",   mem_ai,   15'h0020);

    // Read-back by requester 1.
    next_cycle;
    drive(1, 1'b1, 1'b0, 15'h0010, '0, '0);
    mid;
    check("rd_gnt1",  bus.gnt1,  1);
    check("rd_gnt0",  bus.gnt0,  0);
    check("rd_we",    mem_we,    0);
    check("rd_ai_T",  mem_ai,    15'h0010);
    check("rd_rvld1_T", bus.rvld1, 0);

    // RDAT: data out; a new request from 0 must wait.
    next_cycle;
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    drive(0, 1'b1, 1'b0, 15'h3FFF, '0, '0);
    mid;
    check("rd_rvld1",    bus.rvld1, 1);
    check("rd_vo1",      bus.vo1,   32'hDEAD_BEEF);
    check("rd_ai_T1",    mem_ai,    15'h0010);
    check("rdat_gnt0",   bus.gnt0,  0);
    check("rdat_we",     mem_we,    0);
    check("rdat_rvld0",  bus.rvld0, 0);
    check("rdat_vo0",    bus.vo0,   0);

    // Bank crossing: read 0x3FFF then 0x4000 back to back.
    next_cycle;
    mid;
    check("bx_gnt0_a",  bus.gnt0,  1);
    check("bx_ai_a",    mem_ai,    15'h3FFF);
    check("bx_rvld1_0", bus.rvld1, 0);
    check("bx_vo1_0",   bus.vo1,   0);
    next_cycle;
    drive(0, 1'b1, 1'b0, 15'h4000, '0, '0);
    mid;
    check("bx_rvld0_a", bus.rvld0, 1);
    check("bx_vo0_a",   bus.vo0,   32'h1111_1111);
    check("bx_hold_a",  mem_ai,    15'h3FFF);
    next_cycle;
    mid;
    check("bx_gnt0_b",  bus.gnt0,  1);
    check("bx_ai_b",    mem_ai,    15'h4000);

    // During that RDAT, requester 1 raises a write it then withdraws.
    next_cycle;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b1, 1'b1, 15'h0010, 4'hF, 32'h0000_0000);
    mid;
    check("bx_rvld0_b", bus.rvld0, 1);
    check("bx_vo0_b",   bus.vo0,   32'h2222_2222);
    check("bx_hold_b",  mem_ai,    15'h4000);
    check("wd_gnt1_rdat", bus.gnt1, 0);
    next_cycle;
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    mid;
    check("wd_gnt1", bus.gnt1, 0);
    check("wd_we",   mem_we,   0);

    // Partial-write result.
    next_cycle;
    drive(1, 1'b1, 1'b0, 15'h0020, '0, '0);
    mid;
    check("pw_rd_gnt1", bus.gnt1, 1);
    next_cycle;
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    mid;
    check("pw_rvld1", bus.rvld1, 1);
    check("pw_vo1",   bus.vo1,   32'h1234_BBBB);

    // Withdrawn write left 0x0010 untouched.
    next_cycle;
    drive(1, 1'b1, 1'b0, 15'h0010, '0, '0);
    mid;
    check("wd_rd_gnt1", bus.gnt1, 1);
    next_cycle;
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    mid;
    check("wd_vo1", bus.vo1, 32'hDEAD_BEEF);

    // Contention: both reads held from reset.
    next_cycle;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 15'h0010, '0, '0);
    drive(1, 1'b1, 1'b0, 15'h0020, '0, '0);
    mid;
    check("ct_rst_gnt0", bus.gnt0, 0);
    check("ct_rst_gnt1", bus.gnt1, 0);
    next_cycle;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      mid;
      check($sformatf("ct_gnt0_%0d", i),  bus.gnt0,  (i % 4) == 0);
      check($sformatf("ct_gnt1_%0d", i),  bus.gnt1,  (i % 4) == 2);
      check($sformatf("ct_rvld0_%0d", i), bus.rvld0, (i % 4) == 1);
      check($sformatf("ct_rvld1_%0d", i), bus.rvld1, (i % 4) == 3);
      if ((i % 4) == 1) check($sformatf("ct_vo0_%0d", i), bus.vo0, 32'hDEAD_BEEF);
      next_cycle;
    end

    // Now in RDAT for requester 1: reset aborts the read.
    rst_n = 1'b0;
    mid;
    check("ab_rvld1", bus.rvld1, 0);
    check("ab_vo1",   bus.vo1,   0);
    check("ab_rvld0", bus.rvld0, 0);
    next_cycle;
    mid;
    check("ab_rvld1_hold", bus.rvld1, 0);
    next_cycle;
    rst_n = 1'b1;
    mid;
    check("ab_gnt0_first", bus.gnt0,  1);
    check("ab_gnt1_first", bus.gnt1,  0);
    check("ab_rvld1_rel",  bus.rvld1, 0);
    next_cycle;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    mid;
    check("ab_rvld0_new", bus.rvld0, 1);
    check("ab_vo0_new",   bus.vo0,   32'hDEAD_BEEF);
    check("ab_rvld1_new", bus.rvld1, 0);

    next_cycle;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_spram32_arb
`default_nettype wire
